// File: rtl/set_bit_scheduler_pkg.sv
// Shared types and width helpers for the set-bit scheduler.
// Included by the interface, the trailing-zero counter and the top.
package set_bit_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sbs_state_t;

  // Index width for a request word; clamped so a degenerate width still elaborates.
  function automatic int idx_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

  // Trailing-zero result needs one extra bit to represent "no bit set".
  function automatic int tz_width(input int dw);
    return idx_width(dw) + 1;
  endfunction

endpackage

// File: rtl/set_bit_scheduler_if.sv
// Request-word input and index-stream output of the set-bit scheduler.
// master = traffic source/sink around the block, slave = the scheduler itself.
interface set_bit_scheduler_if
  import set_bit_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  localparam int IDX_W = idx_width(DATA_WIDTH);

  logic                  din_valid;
  logic                  din_ready;
  logic [DATA_WIDTH-1:0] din;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [IDX_W-1:0]      dout_idx;
  logic [IDX_W-1:0]      dout_seq;
  logic                  dout_last;
  logic                  zero_drop;

  modport master (
    output din_valid,
    output din,
    output dout_ready,
    input  din_ready,
    input  dout_valid,
    input  dout_idx,
    input  dout_seq,
    input  dout_last,
    input  zero_drop
  );

  modport slave (
    input  din_valid,
    input  din,
    input  dout_ready,
    output din_ready,
    output dout_valid,
    output dout_idx,
    output dout_seq,
    output dout_last,
    output zero_drop
  );

endinterface

// File: rtl/set_bit_scheduler_tz_count.sv
// Combinational trailing-zero counter; returns DATA_WIDTH for an all-zero vector.
module tz_count
  import set_bit_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           vec,
  output logic [tz_width(DATA_WIDTH)-1:0] count
);

  localparam int CNT_W = tz_width(DATA_WIDTH);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    count = CNT_W'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        count = CNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/set_bit_scheduler.sv
// Serialises the set bits of a request word into an LSB-first index stream,
// one index per output handshake, with back-to-back word loading on the last beat.
module set_bit_scheduler
  import set_bit_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  set_bit_scheduler_if.slave   bus
);

  localparam int IDX_W = idx_width(DATA_WIDTH);
  localparam int CNT_W = tz_width(DATA_WIDTH);

  sbs_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]      seq_q, seq_d;
  logic                  zdrop_q, zdrop_d;

  logic [CNT_W-1:0]      tz;
  logic [DATA_WIDTH-1:0] mask_clr;
  logic                  in_scan;
  logic                  last;
  logic                  out_fire;
  logic                  din_ready;
  logic                  load;

  tz_count #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tz (
    .vec   (mask_q),
    .count (tz)
  );

  assign mask_clr  = mask_q & (mask_q - DATA_WIDTH'(1));
  assign in_scan   = (state_q == SCAN);
  assign last      = in_scan && (mask_clr == '0);
  assign out_fire  = in_scan && bus.dout_ready;
  // dout_ready feeds din_ready combinationally so a new word can load on the last beat.
  assign din_ready = (state_q == IDLE) || (out_fire && last);
  assign load      = bus.din_valid && din_ready;

  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = in_scan;
  assign bus.dout_idx   = in_scan ? tz[IDX_W-1:0] : '0;
  assign bus.dout_seq   = in_scan ? seq_q : '0;
  assign bus.dout_last  = last;
  assign bus.zero_drop  = zdrop_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    zdrop_d = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      SCAN: begin
        if (out_fire) begin
          if (!last) begin
            mask_d = mask_clr;
            seq_d  = seq_q + IDX_W'(1);
          end else begin
            state_d = IDLE;
            mask_d  = '0;
            seq_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        seq_d   = '0;
      end
    endcase

    // A load only happens from IDLE or on the last beat, so it overrides the above.
    if (load) begin
      seq_d = '0;
      if (bus.din != '0) begin
        state_d = SCAN;
        mask_d  = bus.din;
      end else begin
        state_d = IDLE;
        mask_d  = '0;
        zdrop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      seq_q   <= '0;
      zdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      zdrop_q <= zdrop_d;
    end
  end

endmodule

// File: tb/tb_set_bit_scheduler.sv
// Directed bench for set_bit_scheduler at DATA_WIDTH=8 with hand-computed expectations.
module tb_set_bit_scheduler;

  localparam int DW = 8;

  logic clk;
  logic resetn;

  int n_chk  = 0;
  int n_pass = 0;

  set_bit_scheduler_if #(.DATA_WIDTH(DW)) bus_if ();

  set_bit_scheduler #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [DW-1:0] word);
    bus_if.din       = word;
    bus_if.din_valid = 1'b1;
    tick();
    bus_if.din_valid = 1'b0;
  endtask

  // One output beat with dout_ready high: check it, then let the handshake happen.
  task automatic beat(input string tag, input int idx, input int seq, input logic lst);
    #1;
    chk({tag, ".valid"}, bus_if.dout_valid, 1);
    chk({tag, ".idx"},   bus_if.dout_idx, idx);
    chk({tag, ".seq"},   bus_if.dout_seq, seq);
    chk({tag, ".last"},  bus_if.dout_last, lst);
    chk({tag, ".rdy"},   bus_if.din_ready, lst);
    tick();
  endtask

  initial begin
    resetn            = 1'b0;
    bus_if.din_valid  = 1'b0;
    bus_if.din        = '0;
    bus_if.dout_ready = 1'b1;
    #2;
    chk("rst.valid", bus_if.dout_valid, 0);
    chk("rst.idx",   bus_if.dout_idx, 0);
    chk("rst.seq",   bus_if.dout_seq, 0);
    chk("rst.last",  bus_if.dout_last, 0);
    chk("rst.zdrop", bus_if.zero_drop, 0);
    chk("rst.rdy",   bus_if.din_ready, 1);
    #10 resetn = 1'b1;
    tick();
    chk("rel.valid", bus_if.dout_valid, 0);

    // Three set bits: 2, 4, 7
    accept(8'b1001_0100);
    beat("t1b0", 2, 0, 1'b0);
    beat("t1b1", 4, 1, 1'b0);
    beat("t1b2", 7, 2, 1'b1);
    chk("t1.idle", bus_if.dout_valid, 0);
    chk("t1.rdy",  bus_if.din_ready, 1);

    // All-zero word is dropped with a single-cycle pulse
    accept(8'h00);
    chk("t2.zd1",   bus_if.zero_drop, 1);
    chk("t2.valid", bus_if.dout_valid, 0);
    chk("t2.rdy",   bus_if.din_ready, 1);
    tick();
    chk("t2.zd0",   bus_if.zero_drop, 0);
    chk("t2.vld0",  bus_if.dout_valid, 0);

    // Back-to-back: 8'h01 loads on the last beat of 8'h80
    accept(8'h80);
    bus_if.din       = 8'h01;
    bus_if.din_valid = 1'b1;
    beat("t3a", 7, 0, 1'b1);
    bus_if.din_valid = 1'b0;
    beat("t3b", 0, 0, 1'b1);
    chk("t3.idle", bus_if.dout_valid, 0);

    // Backpressure: outputs frozen, din (8'hFF) ignored while stalled
    accept(8'b0110_0000);
    bus_if.dout_ready = 1'b0;
    bus_if.din        = 8'hFF;
    bus_if.din_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4.idx",  bus_if.dout_idx, 5);
      chk("t4.seq",  bus_if.dout_seq, 0);
      chk("t4.last", bus_if.dout_last, 0);
      chk("t4.vld",  bus_if.dout_valid, 1);
      chk("t4.rdy",  bus_if.din_ready, 0);
      tick();
    end
    bus_if.din_valid  = 1'b0;
    bus_if.dout_ready = 1'b1;
    beat("t4b0", 5, 0, 1'b0);
    beat("t4b1", 6, 1, 1'b1);
    chk("t4.idle", bus_if.dout_valid, 0);

    // All ones: eight beats, last only on idx 7
    accept(8'hFF);
    for (int i = 0; i < 8; i++) begin
      beat("t5", i, i, (i == 7));
    end
    chk("t5.idle", bus_if.dout_valid, 0);

    // Reset mid-scan discards remaining indices
    accept(8'b1010_1010);
    beat("t6b0", 1, 0, 1'b0);
    beat("t6b1", 3, 1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("t6.rvld", bus_if.dout_valid, 0);
    chk("t6.ridx", bus_if.dout_idx, 0);
    chk("t6.rrdy", bus_if.din_ready, 1);
    tick();
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.pvld", bus_if.dout_valid, 0);
      chk("t6.prdy", bus_if.din_ready, 1);
    end
    accept(8'h04);
    beat("t6n", 2, 0, 1'b1);
    chk("t6.idle", bus_if.dout_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
